adma_dm_gearbox_buf: RTL and testbench

Parametrised data buffer placed between the read host and the write host of the ADMA data mover. It replaces the fixed-width pass-through buffer. It supports unequal source and destination data widths (integer power-of-two up- or down-sizing) and a configurable FIFO depth. It propagates a per-beat last flag and provides occupancy reporting and a synchronous flush, so a channel abort can drain the path without a reset.

---
 rtl/adma_dm_gearbox_buf.sv | 145 ++++++++++++++
 tb/tb_adma_dm_gearbox_buf.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_dm_gearbox_buf.sv
// rtl/adma_dm_gearbox_buf.sv - width-converting FIFO between the ADMA read and write hosts
module adma_dm_gearbox_buf #(
    parameter int ATX_SRC_DATA_W = 256,
    parameter int ATX_DST_DATA_W = 256,
    parameter int BUF_DEPTH      = 4,
    localparam int ENT_W = (ATX_SRC_DATA_W > ATX_DST_DATA_W) ? ATX_SRC_DATA_W : ATX_DST_DATA_W,
    localparam int MIN_W = (ATX_SRC_DATA_W > ATX_DST_DATA_W) ? ATX_DST_DATA_W : ATX_SRC_DATA_W,
    localparam int RATIO = ENT_W / MIN_W,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic [ATX_SRC_DATA_W-1:0] src_data,
    input  logic                      src_last,
    input  logic                      src_vld,
    output logic                      src_rdy,
    output logic [ATX_DST_DATA_W-1:0] dst_data,
    output logic                      dst_last,
    output logic                      dst_vld,
    input  logic                      dst_rdy,
    output logic [CNT_W-1:0]          buf_cnt,
    output logic                      buf_empty
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam bit UPSIZE = ATX_DST_DATA_W > ATX_SRC_DATA_W;
    localparam bit DNSIZE = ATX_SRC_DATA_W > ATX_DST_DATA_W;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

    logic [ENT_W-1:0]     mem_data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] mem_last_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] lidx_q, lidx_d;
    logic [IDX_W-1:0] sidx_q, sidx_d;
    logic [ENT_W-1:0] pack_q, pack_d;

    logic             full;
    logic             fifo_empty;
    logic             src_acc;
    logic             dst_acc;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] lane_data;
    logic [ENT_W-1:0] push_data;
    logic [ENT_W-1:0] head_data;
    logic             head_last;

    // Handshake decode; lane/slice indices stay at zero outside their own mode,
    // so the same shift expressions serve all three width relationships.
    always_comb begin
        full       = (cnt_q == CNT_FULL);
        fifo_empty = (cnt_q == '0);
        src_rdy    = !full && !flush_i;
        dst_vld    = !fifo_empty && !flush_i;
        src_acc    = src_vld && src_rdy;
        dst_acc    = dst_vld && dst_rdy;
        push       = src_acc && (!UPSIZE || (lidx_q == IDX_MAX) || src_last);
        pop        = dst_acc && (!DNSIZE || (sidx_q == IDX_MAX));
        lane_data  = ENT_W'(src_data) << (int'(lidx_q) * ATX_SRC_DATA_W);
        push_data  = pack_q | lane_data;
        head_data  = mem_data_q[rd_ptr_q];
        head_last  = mem_last_q[rd_ptr_q];
        dst_data   = fifo_empty ? '0
                   : ATX_DST_DATA_W'(head_data >> (int'(sidx_q) * ATX_DST_DATA_W));
        dst_last   = !fifo_empty && head_last && (!DNSIZE || (sidx_q == IDX_MAX));
        buf_cnt    = cnt_q;
        buf_empty  = fifo_empty && (lidx_q == '0) && (sidx_q == '0);
    end

    // Next-state for pointers, occupancy, pack and slice tracking; flush wins.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        lidx_d   = lidx_q;
        sidx_d   = sidx_q;
        pack_d   = pack_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            lidx_d   = '0;
            sidx_d   = '0;
            pack_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (push) begin
                lidx_d = '0;
                pack_d = '0;
            end else if (src_acc) begin
                lidx_d = lidx_q + IDX_W'(1);
                pack_d = push_data;
            end
            if (pop) begin
                sidx_d = '0;
            end else if (dst_acc) begin
                sidx_d = sidx_q + IDX_W'(1);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            lidx_q   <= '0;
            sidx_q   <= '0;
            pack_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            lidx_q   <= lidx_d;
            sidx_q   <= sidx_d;
            pack_q   <= pack_d;
        end
    end

    // Entry storage; contents are qualified by the counter so they carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_last_q[wr_ptr_q] <= src_last;
        end
    end

endmodule

// File: tb/tb_adma_dm_gearbox_buf.sv
// tb/tb_adma_dm_gearbox_buf.sv - scoreboard bench for equal, upsize and downsize buffers
module tb_adma_dm_gearbox_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // equal widths 256/256
    logic         e_flush = 0, e_src_last = 0, e_src_vld = 0, e_src_rdy;
    logic [255:0] e_src_data = '0, e_dst_data;
    logic         e_dst_last, e_dst_vld, e_dst_rdy = 0, e_buf_empty;
    logic [2:0]   e_buf_cnt;
    // upsize 64->256
    logic         u_flush = 0, u_src_last = 0, u_src_vld = 0, u_src_rdy;
    logic [63:0]  u_src_data = '0;
    logic [255:0] u_dst_data;
    logic         u_dst_last, u_dst_vld, u_dst_rdy = 0, u_buf_empty;
    logic [2:0]   u_buf_cnt;
    // downsize 256->64
    logic         d_flush = 0, d_src_last = 0, d_src_vld = 0, d_src_rdy;
    logic [255:0] d_src_data = '0;
    logic [63:0]  d_dst_data;
    logic         d_dst_last, d_dst_vld, d_dst_rdy = 0, d_buf_empty;
    logic [2:0]   d_buf_cnt;

    adma_dm_gearbox_buf #(.ATX_SRC_DATA_W(256), .ATX_DST_DATA_W(256), .BUF_DEPTH(4)) u_eq (
        .clk(clk), .rst_n(rst_n), .flush_i(e_flush),
        .src_data(e_src_data), .src_last(e_src_last), .src_vld(e_src_vld), .src_rdy(e_src_rdy),
        .dst_data(e_dst_data), .dst_last(e_dst_last), .dst_vld(e_dst_vld), .dst_rdy(e_dst_rdy),
        .buf_cnt(e_buf_cnt), .buf_empty(e_buf_empty));

    adma_dm_gearbox_buf #(.ATX_SRC_DATA_W(64), .ATX_DST_DATA_W(256), .BUF_DEPTH(4)) u_up (
        .clk(clk), .rst_n(rst_n), .flush_i(u_flush),
        .src_data(u_src_data), .src_last(u_src_last), .src_vld(u_src_vld), .src_rdy(u_src_rdy),
        .dst_data(u_dst_data), .dst_last(u_dst_last), .dst_vld(u_dst_vld), .dst_rdy(u_dst_rdy),
        .buf_cnt(u_buf_cnt), .buf_empty(u_buf_empty));

    adma_dm_gearbox_buf #(.ATX_SRC_DATA_W(256), .ATX_DST_DATA_W(64), .BUF_DEPTH(4)) u_dn (
        .clk(clk), .rst_n(rst_n), .flush_i(d_flush),
        .src_data(d_src_data), .src_last(d_src_last), .src_vld(d_src_vld), .src_rdy(d_src_rdy),
        .dst_data(d_dst_data), .dst_last(d_dst_last), .dst_vld(d_dst_vld), .dst_rdy(d_dst_rdy),
        .buf_cnt(d_buf_cnt), .buf_empty(d_buf_empty));

    // scoreboards: {last, data}
    logic [256:0] q_e[$];
    logic [256:0] q_u[$];
    logic [64:0]  q_d[$];
    logic [255:0] u_pk = '0;
    int           u_lane = 0;

    task automatic chk(input string tag, input bit ok, input logic [259:0] obs, input logic [259:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q_e.size() : (sel == 1) ? q_u.size() : q_d.size();
    endfunction

    task automatic push_e(input logic [255:0] d, input logic l);
        int n = 0;
        e_src_data = d; e_src_last = l; e_src_vld = 1;
        @(negedge clk);
        while (!e_src_rdy && n < 300) begin n++; @(negedge clk); end
        if (!e_src_rdy) chk("eq_push_timeout", n === 0, 260'(n), 260'(0));
        else q_e.push_back({l, d});
        @(posedge clk); #1;
        e_src_vld = 0;
    endtask

    task automatic push_u(input logic [63:0] d, input logic l);
        int n = 0;
        u_src_data = d; u_src_last = l; u_src_vld = 1;
        @(negedge clk);
        while (!u_src_rdy && n < 300) begin n++; @(negedge clk); end
        if (!u_src_rdy) chk("up_push_timeout", n === 0, 260'(n), 260'(0));
        else begin
            u_pk = u_pk | (256'(d) << (64 * u_lane));
            if (u_lane == 3 || l) begin
                q_u.push_back({l, u_pk});
                u_pk = '0; u_lane = 0;
            end else u_lane++;
        end
        @(posedge clk); #1;
        u_src_vld = 0;
    endtask

    task automatic push_d(input logic [255:0] d, input logic l);
        int n = 0;
        d_src_data = d; d_src_last = l; d_src_vld = 1;
        @(negedge clk);
        while (!d_src_rdy && n < 300) begin n++; @(negedge clk); end
        if (!d_src_rdy) chk("dn_push_timeout", n === 0, 260'(n), 260'(0));
        else for (int k = 0; k < 4; k++) q_d.push_back({(k == 3) && l, d[64*k +: 64]});
        @(posedge clk); #1;
        d_src_vld = 0;
    endtask

    task automatic drain(input int sel);
        int n = 0;
        while (qsize(sel) != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain_timeout", qsize(sel) === 0, 260'(qsize(sel)), 260'(0));
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_eq_src_rdy", e_src_rdy === 1'b1, 260'(e_src_rdy), 260'(1));
        chk("rst_eq_dst_vld", e_dst_vld === 1'b0, 260'(e_dst_vld), 260'(0));
        chk("rst_eq_dst_last", e_dst_last === 1'b0, 260'(e_dst_last), 260'(0));
        chk("rst_eq_cnt", e_buf_cnt === 3'd0, 260'(e_buf_cnt), 260'(0));
        chk("rst_eq_empty", e_buf_empty === 1'b1, 260'(e_buf_empty), 260'(1));
        chk("rst_eq_data", e_dst_data === 256'd0, 260'(e_dst_data), 260'(0));
        chk("rst_up_src_rdy", u_src_rdy === 1'b1, 260'(u_src_rdy), 260'(1));
        chk("rst_up_dst_vld", u_dst_vld === 1'b0, 260'(u_dst_vld), 260'(0));
        chk("rst_up_dst_last", u_dst_last === 1'b0, 260'(u_dst_last), 260'(0));
        chk("rst_up_cnt", u_buf_cnt === 3'd0, 260'(u_buf_cnt), 260'(0));
        chk("rst_up_empty", u_buf_empty === 1'b1, 260'(u_buf_empty), 260'(1));
        chk("rst_up_data", u_dst_data === 256'd0, 260'(u_dst_data), 260'(0));
        chk("rst_dn_src_rdy", d_src_rdy === 1'b1, 260'(d_src_rdy), 260'(1));
        chk("rst_dn_dst_vld", d_dst_vld === 1'b0, 260'(d_dst_vld), 260'(0));
        chk("rst_dn_dst_last", d_dst_last === 1'b0, 260'(d_dst_last), 260'(0));
        chk("rst_dn_cnt", d_buf_cnt === 3'd0, 260'(d_buf_cnt), 260'(0));
        chk("rst_dn_empty", d_buf_empty === 1'b1, 260'(d_buf_empty), 260'(1));
        chk("rst_dn_data", d_dst_data === 64'd0, 260'(d_dst_data), 260'(0));
    endtask

    task automatic scen_eq_fill();
        e_dst_rdy = 0;
        push_e(256'h1, 0);
        chk("eq_latency_vld", e_dst_vld === 1'b1, 260'(e_dst_vld), 260'(1));
        for (int i = 2; i <= 4; i++) push_e(256'(i), 0);
        chk("eq_full_src_rdy", e_src_rdy === 1'b0, 260'(e_src_rdy), 260'(0));
        chk("eq_full_cnt", e_buf_cnt === 3'd4, 260'(e_buf_cnt), 260'(4));
        e_dst_rdy = 1;
        @(negedge clk);
        chk("eq_first_out", e_dst_data === 256'h1, 260'(e_dst_data), 260'(1));
        @(posedge clk); #1;
        chk("eq_rdy_after_pop", e_src_rdy === 1'b1, 260'(e_src_rdy), 260'(1));
        drain(0);
        chk("eq_drained_cnt", e_buf_cnt === 3'd0, 260'(e_buf_cnt), 260'(0));
    endtask

    logic [256:0] e_hold, u_hold, e_exp, u_exp;
    logic [64:0]  d_hold, d_exp;
    logic         e_stall = 0, u_stall = 0, d_stall = 0;

    always @(negedge clk) begin
        if (!rst_n) e_stall = 0;
        else begin
            if (e_stall && e_dst_vld)
                chk("eq_stable", {e_dst_last, e_dst_data} === e_hold, 260'({e_dst_last, e_dst_data}), 260'(e_hold));
            if (e_dst_vld && e_dst_rdy) begin
                if (q_e.size() == 0) chk("eq_unexpected", q_e.size() === 1, 260'(q_e.size()), 260'(1));
                else begin
                    e_exp = q_e.pop_front();
                    chk("eq_beat", {e_dst_last, e_dst_data} === e_exp, 260'({e_dst_last, e_dst_data}), 260'(e_exp));
                end
            end
            e_stall = e_dst_vld && !e_dst_rdy;
            e_hold  = {e_dst_last, e_dst_data};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) u_stall = 0;
        else begin
            if (u_stall && u_dst_vld)
                chk("up_stable", {u_dst_last, u_dst_data} === u_hold, 260'({u_dst_last, u_dst_data}), 260'(u_hold));
            if (u_dst_vld && u_dst_rdy) begin
                if (q_u.size() == 0) chk("up_unexpected", q_u.size() === 1, 260'(q_u.size()), 260'(1));
                else begin
                    u_exp = q_u.pop_front();
                    chk("up_beat", {u_dst_last, u_dst_data} === u_exp, 260'({u_dst_last, u_dst_data}), 260'(u_exp));
                end
            end
            u_stall = u_dst_vld && !u_dst_rdy;
            u_hold  = {u_dst_last, u_dst_data};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) d_stall = 0;
        else begin
            if (d_stall && d_dst_vld)
                chk("dn_stable", {d_dst_last, d_dst_data} === d_hold, 260'({d_dst_last, d_dst_data}), 260'(d_hold));
            if (d_dst_vld && d_dst_rdy) begin
                if (q_d.size() == 0) chk("dn_unexpected", q_d.size() === 1, 260'(q_d.size()), 260'(1));
                else begin
                    d_exp = q_d.pop_front();
                    chk("dn_beat", {d_dst_last, d_dst_data} === d_exp, 260'({d_dst_last, d_dst_data}), 260'(d_exp));
                end
            end
            d_stall = d_dst_vld && !d_dst_rdy;
            d_hold  = {d_dst_last, d_dst_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    logic bp_run;

    initial begin
        #2;
        chk_reset_outs();
        @(posedge clk); #1;
        rst_n = 1;

        scen_eq_fill();

        e_dst_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            push_e(256'(32'h100 + i), (i == 19));
            chk("eq_wrap_cnt", e_buf_cnt === 3'd1, 260'(e_buf_cnt), 260'(1));
        end
        drain(0);

        u_dst_rdy = 0;
        push_u(64'hA, 0);
        chk("up_partial_vld", u_dst_vld === 1'b0, 260'(u_dst_vld), 260'(0));
        chk("up_partial_empty", u_buf_empty === 1'b0, 260'(u_buf_empty), 260'(0));
        push_u(64'hB, 0);
        push_u(64'hC, 0);
        push_u(64'hD, 1);
        chk("up_latency_vld", u_dst_vld === 1'b1, 260'(u_dst_vld), 260'(1));
        chk("up_cnt1", u_buf_cnt === 3'd1, 260'(u_buf_cnt), 260'(1));
        push_u(64'h5, 0);
        push_u(64'h6, 1);
        chk("up_cnt2", u_buf_cnt === 3'd2, 260'(u_buf_cnt), 260'(2));
        u_dst_rdy = 1;
        drain(1);

        d_dst_rdy = 0;
        push_d({64'h4, 64'h3, 64'h2, 64'h1}, 1);
        chk("dn_cnt_after_push", d_buf_cnt === 3'd1, 260'(d_buf_cnt), 260'(1));
        chk("dn_latency_vld", d_dst_vld === 1'b1, 260'(d_dst_vld), 260'(1));
        d_dst_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("dn_cnt_hold", d_buf_cnt === 3'd1, 260'(d_buf_cnt), 260'(1));
            @(posedge clk); #1;
        end
        chk("dn_cnt_after_pop", d_buf_cnt === 3'd0, 260'(d_buf_cnt), 260'(0));
        chk("dn_empty_after_pop", d_buf_empty === 1'b1, 260'(d_buf_empty), 260'(1));

        bp_run = 1;
        fork
            begin
                for (int i = 0; i < 64; i++) push_e(rnd256(), 1'($urandom_range(0, 1)));
                for (int i = 0; i < 16; i++) push_d(rnd256(), 1'($urandom_range(0, 1)));
                bp_run = 0;
            end
            begin
                while (bp_run) begin
                    @(posedge clk); #1;
                    e_dst_rdy = 1'($urandom_range(0, 1));
                    d_dst_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        e_dst_rdy = 1; d_dst_rdy = 1;
        drain(0);
        drain(2);

        u_dst_rdy = 0;
        for (int i = 0; i < 14; i++) push_u(64'(32'h200 + i), 0);
        chk("fl_pre_cnt", u_buf_cnt === 3'd3, 260'(u_buf_cnt), 260'(3));
        chk("fl_pre_empty", u_buf_empty === 1'b0, 260'(u_buf_empty), 260'(0));
        u_flush = 1;
        @(negedge clk);
        chk("fl_src_rdy", u_src_rdy === 1'b0, 260'(u_src_rdy), 260'(0));
        chk("fl_dst_vld", u_dst_vld === 1'b0, 260'(u_dst_vld), 260'(0));
        @(posedge clk); #1;
        u_flush = 0;
        q_u.delete(); u_pk = '0; u_lane = 0;
        chk("fl_post_cnt", u_buf_cnt === 3'd0, 260'(u_buf_cnt), 260'(0));
        chk("fl_post_empty", u_buf_empty === 1'b1, 260'(u_buf_empty), 260'(1));
        for (int i = 0; i < 4; i++) push_u(64'(32'h300 + i), 0);
        chk("fl_clean_cnt", u_buf_cnt === 3'd1, 260'(u_buf_cnt), 260'(1));
        u_dst_rdy = 1;
        drain(1);

        e_dst_rdy = 0; u_dst_rdy = 0;
        push_e(256'h77, 0);
        push_e(256'h78, 0);
        push_u(64'h99, 0);
        #3;
        rst_n = 0;
        #1;
        chk_reset_outs();
        q_e.delete(); q_u.delete(); q_d.delete(); u_pk = '0; u_lane = 0;
        @(posedge clk); #1;
        rst_n = 1;
        scen_eq_fill();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
